// File: rtl/knn_pkg.sv
// Shared types and default sizes for the k-NN datapath blocks.
package knn_pkg;

    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_NUM_DIMS    = 32;
    localparam int DEF_NUM_VECTORS = 16;

    // A single reference vector still needs a one-bit index field.
    function automatic int vec_width(input int num_vectors);
        return (num_vectors > 1) ? $clog2(num_vectors) : 1;
    endfunction

    localparam int DEF_VEC_WIDTH = vec_width(DEF_NUM_VECTORS);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        DONE
    } state_e;

    typedef struct packed {
        logic [DEF_DATA_WIDTH-1:0] data1;
        logic [DEF_DATA_WIDTH-1:0] data2;
        logic                      first;
        logic                      last;
        logic [DEF_VEC_WIDTH-1:0]  vec;
    } pair_t;

endpackage

// File: rtl/pair_skid_fifo.sv
// Two-entry FIFO with a registered head; the head only moves on pop or
// when the FIFO is empty, so the output holds steady under backpressure.
module pair_skid_fifo
    import knn_pkg::*;
#(
    parameter type T = pair_t
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  T           in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output T           out_data,
    output logic [1:0] count
);

    T           head_q, head_d;
    T           skid_q, skid_d;
    logic [1:0] count_q, count_d;
    logic       push, pop;

    always_comb begin
        out_valid = (count_q != 2'd0);
        in_ready  = (count_q != 2'd2) || out_ready;
        pop       = out_valid && out_ready;
        push      = in_valid && in_ready;
        head_d    = head_q;
        skid_d    = skid_q;
        count_d   = count_q + {1'b0, push} - {1'b0, pop};
        if (pop && count_q == 2'd2)
            head_d = skid_q;
        else if (push && (count_q == 2'd0 || (count_q == 2'd1 && pop)))
            head_d = in_data;
        if (push && ((count_q == 2'd1 && !pop) || (count_q == 2'd2 && pop)))
            skid_d = in_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            skid_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            skid_q  <= skid_d;
            count_q <= count_d;
        end
    end

    assign out_data = head_q;
    assign count    = count_q;

endmodule

// File: rtl/vector_pair_streamer.sv
// Streams (query[d], ref[j][d]) pairs from two 1-cycle-latency memories,
// credit-limited so the 2-entry output buffer never overflows.
module vector_pair_streamer
    import knn_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int NUM_DIMS     = DEF_NUM_DIMS,
    parameter int NUM_VECTORS  = DEF_NUM_VECTORS,
    parameter int Q_ADDR_WIDTH = $clog2(NUM_DIMS),
    parameter int R_ADDR_WIDTH = $clog2(NUM_DIMS * NUM_VECTORS),
    parameter int VEC_WIDTH    = vec_width(NUM_VECTORS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    q_rd_en,
    output logic [Q_ADDR_WIDTH-1:0] q_addr,
    input  logic [DATA_WIDTH-1:0]   q_rdata,
    output logic                    r_rd_en,
    output logic [R_ADDR_WIDTH-1:0] r_addr,
    input  logic [DATA_WIDTH-1:0]   r_rdata,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   data1,
    output logic [DATA_WIDTH-1:0]   data2,
    output logic                    out_first,
    output logic                    out_last,
    output logic [VEC_WIDTH-1:0]    out_vec
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data1;
        logic [DATA_WIDTH-1:0] data2;
        logic                  first;
        logic                  last;
        logic [VEC_WIDTH-1:0]  vec;
    } pair_w_t;

    localparam logic [Q_ADDR_WIDTH-1:0] LAST_D = Q_ADDR_WIDTH'(NUM_DIMS - 1);
    localparam logic [VEC_WIDTH-1:0]    LAST_J = VEC_WIDTH'(NUM_VECTORS - 1);

    state_e                  state_q, state_d;
    logic [Q_ADDR_WIDTH-1:0] d_q, d_d;
    logic [VEC_WIDTH-1:0]    j_q, j_d;
    logic                    inflight_q, inflight_d;
    logic                    tag_first_q, tag_first_d;
    logic                    tag_last_q, tag_last_d;
    logic [VEC_WIDTH-1:0]    tag_vec_q, tag_vec_d;
    logic                    rd_en, pop, fifo_in_ready;
    logic [1:0]              fifo_count;
    logic [2:0]              occ;
    pair_w_t                 in_pair, out_pair;

    // Occupancy net of this cycle's pop, so a freed slot is refilled at once
    // and ready held high gives one pair per cycle.
    assign pop = out_valid && out_ready;
    assign occ = {1'b0, fifo_count} + {2'b0, inflight_q} - {2'b0, pop};

    always_comb begin
        state_d     = state_q;
        d_d         = d_q;
        j_d         = j_q;
        rd_en       = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        tag_first_d = tag_first_q;
        tag_last_d  = tag_last_q;
        tag_vec_d   = tag_vec_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                    d_d     = '0;
                    j_d     = '0;
                end
            end
            FETCH: begin
                busy = 1'b1;
                if (occ < 3'd2 && fifo_in_ready) begin
                    rd_en       = 1'b1;
                    tag_first_d = (d_q == '0);
                    tag_last_d  = (d_q == LAST_D);
                    tag_vec_d   = j_q;
                    if (d_q == LAST_D) begin
                        d_d = '0;
                        if (j_q == LAST_J) begin
                            j_d     = '0;
                            state_d = DRAIN;
                        end else begin
                            j_d = j_q + 1'b1;
                        end
                    end else begin
                        d_d = d_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (occ == 3'd0) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        inflight_d = rd_en;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            d_q         <= '0;
            j_q         <= '0;
            inflight_q  <= 1'b0;
            tag_first_q <= 1'b0;
            tag_last_q  <= 1'b0;
            tag_vec_q   <= '0;
        end else begin
            state_q     <= state_d;
            d_q         <= d_d;
            j_q         <= j_d;
            inflight_q  <= inflight_d;
            tag_first_q <= tag_first_d;
            tag_last_q  <= tag_last_d;
            tag_vec_q   <= tag_vec_d;
        end
    end

    always_comb begin
        in_pair       = '0;
        in_pair.data1 = q_rdata;
        in_pair.data2 = r_rdata;
        in_pair.first = tag_first_q;
        in_pair.last  = tag_last_q;
        in_pair.vec   = tag_vec_q;
    end

    pair_skid_fifo #(.T(pair_w_t)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (inflight_q),
        .in_ready  (fifo_in_ready),
        .in_data   (in_pair),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_pair),
        .count     (fifo_count)
    );

    assign q_rd_en   = rd_en;
    assign r_rd_en   = rd_en;
    assign q_addr    = d_q;
    assign r_addr    = R_ADDR_WIDTH'(32'(j_q) * 32'(NUM_DIMS) + 32'(d_q));
    assign data1     = out_pair.data1;
    assign data2     = out_pair.data2;
    assign out_first = out_pair.first;
    assign out_last  = out_pair.last;
    assign out_vec   = out_pair.vec;

endmodule

// File: tb/tb_vector_pair_streamer.sv
// Directed bench: a 4x2 streamer (backpressure, re-start, mid-run reset,
// back-to-back runs) and a 2x1 streamer for the minimal-size case.
module tb_vector_pair_streamer;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // instance A: NUM_DIMS=4, NUM_VECTORS=2
    logic        a_start, a_busy, a_done, a_q_rd_en, a_r_rd_en, a_valid, a_ready;
    logic [1:0]  a_q_addr;
    logic [2:0]  a_r_addr;
    logic [31:0] a_q_rdata, a_r_rdata, a_d1, a_d2;
    logic        a_first, a_last;
    logic [0:0]  a_vec;
    logic [31:0] qa [4];
    logic [31:0] ra [8];

    // instance B: NUM_DIMS=2, NUM_VECTORS=1
    logic        b_start, b_busy, b_done, b_q_rd_en, b_r_rd_en, b_valid, b_ready;
    logic [0:0]  b_q_addr, b_r_addr;
    logic [31:0] b_q_rdata, b_r_rdata, b_d1, b_d2;
    logic        b_first, b_last;
    logic [0:0]  b_vec;
    logic [31:0] qb [2];
    logic [31:0] rb [2];

    vector_pair_streamer #(.DATA_WIDTH(32), .NUM_DIMS(4), .NUM_VECTORS(2)) u_a (
        .clk(clk), .reset(rst), .start(a_start), .busy(a_busy), .done(a_done),
        .q_rd_en(a_q_rd_en), .q_addr(a_q_addr), .q_rdata(a_q_rdata),
        .r_rd_en(a_r_rd_en), .r_addr(a_r_addr), .r_rdata(a_r_rdata),
        .out_valid(a_valid), .out_ready(a_ready), .data1(a_d1), .data2(a_d2),
        .out_first(a_first), .out_last(a_last), .out_vec(a_vec)
    );

    vector_pair_streamer #(.DATA_WIDTH(32), .NUM_DIMS(2), .NUM_VECTORS(1)) u_b (
        .clk(clk), .reset(rst), .start(b_start), .busy(b_busy), .done(b_done),
        .q_rd_en(b_q_rd_en), .q_addr(b_q_addr), .q_rdata(b_q_rdata),
        .r_rd_en(b_r_rd_en), .r_addr(b_r_addr), .r_rdata(b_r_rdata),
        .out_valid(b_valid), .out_ready(b_ready), .data1(b_d1), .data2(b_d2),
        .out_first(b_first), .out_last(b_last), .out_vec(b_vec)
    );

    // synchronous-read memories, 1-cycle latency
    always @(posedge clk) begin
        if (a_q_rd_en) a_q_rdata <= qa[a_q_addr];
        if (a_r_rd_en) a_r_rdata <= ra[a_r_addr];
        if (b_q_rd_en) b_q_rdata <= qb[b_q_addr];
        if (b_r_rd_en) b_r_rdata <= rb[b_r_addr];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // mode 0: ready high; 1: random ready; 2: re-pulse start in FETCH and on done.
    // Called at #1 after a rising edge; returns at #1 after a rising edge.
    task automatic run_a(input int mode, input int tail);
        int rel, t0, nhs, issued, ndone, done_rel, last_rel, stalls, idx;
        bit stalled, hs;
        logic [63:0] held_d, held_t;
        nhs = 0; issued = 0; ndone = 0; done_rel = 1000; last_rel = -1;
        stalls = 0; stalled = 0; held_d = '0; held_t = '0;
        t0 = cyc; rel = 0;
        a_start = 1'b1; a_ready = 1'b1;
        while (rel < 150 && rel <= done_rel + tail) begin
            @(negedge clk);
            hs = a_valid && a_ready;
            if (stalled) begin
                chk("hold_data", {a_d1, a_d2}, held_d);
                chk("hold_tags", 64'({a_first, a_last, a_vec}), held_t);
            end
            if (a_q_rd_en || a_r_rd_en) begin
                chk("rd_en_pair", 64'(a_r_rd_en), 64'(a_q_rd_en));
                chk("credit", 64'((issued - nhs - int'(hs)) < 2), 64'(1));
                chk("r_addr", 64'(a_r_addr), 64'(issued));
                chk("q_addr", 64'(a_q_addr), 64'(issued % 4));
                issued++;
            end
            if (rel == 1) chk("busy_run", 64'(a_busy), 64'(1));
            if (hs) begin
                idx = nhs;
                chk("data1", 64'(a_d1), 64'(idx % 4 + 1));
                chk("data2", 64'(a_d2), 64'(idx + 5));
                chk("tags", 64'({a_first, a_last, a_vec}),
                    64'({idx % 4 == 0, idx % 4 == 3, idx / 4 == 1}));
                if (idx == 0 && mode != 1) chk("first_cyc", 64'(rel), 64'(3));
                last_rel = rel;
                nhs++;
            end
            stalled = a_valid && !a_ready;
            if (stalled) begin
                stalls++;
                held_d = {a_d1, a_d2};
                held_t = 64'({a_first, a_last, a_vec});
            end
            if (a_done) begin
                ndone++;
                if (ndone == 1) done_rel = rel;
            end
            @(posedge clk); #1;
            rel = cyc - t0;
            a_start = (mode == 2) && (rel == 4 || rel == 11);
            a_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        a_start = 1'b0; a_ready = 1'b1;
        chk("npairs", 64'(nhs), 64'(8));
        chk("ndone", 64'(ndone), 64'(1));
        chk("done_cyc", 64'(done_rel), 64'(last_rel + 1));
        chk("run_len", 64'(last_rel), 64'(10 + stalls));
        chk("busy_end", 64'(a_busy), 64'(0));
    endtask

    task automatic run_b;
        int t0, rel, n, done_rel;
        n = 0; done_rel = -1; t0 = cyc; rel = 0;
        b_start = 1'b1; b_ready = 1'b1;
        while (rel < 40 && (done_rel < 0 || rel <= done_rel + 1)) begin
            @(negedge clk);
            if (b_valid && b_ready) begin
                if (n == 0) begin
                    chk("b_p0_data", {b_d1, b_d2}, {32'd7, 32'd20});
                    chk("b_p0_tags", 64'({b_first, b_last, b_vec}), 64'(3'b100));
                    chk("b_p0_cyc", 64'(rel), 64'(3));
                end else if (n == 1) begin
                    chk("b_p1_data", {b_d1, b_d2}, {32'd9, 32'd30});
                    chk("b_p1_tags", 64'({b_first, b_last, b_vec}), 64'(3'b010));
                    chk("b_p1_cyc", 64'(rel), 64'(4));
                end
                n++;
            end
            if (b_done && done_rel < 0) done_rel = rel;
            @(posedge clk); #1;
            rel = cyc - t0;
            b_start = 1'b0;
        end
        chk("b_npairs", 64'(n), 64'(2));
        chk("b_done_cyc", 64'(done_rel), 64'(5));
    endtask

    task automatic reset_mid_run;
        int n;
        n = 0;
        a_start = 1'b1; a_ready = 1'b1;
        for (int i = 0; i < 20 && n < 2; i++) begin
            @(negedge clk);
            if (a_valid && a_ready) n++;
            @(posedge clk); #1;
            a_start = 1'b0;
        end
        chk("pre_rst_beats", 64'(n), 64'(2));
        a_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", 64'(a_valid), 64'(0));
        chk("rst_busy", 64'(a_busy), 64'(0));
        chk("rst_rd_en", 64'({a_q_rd_en, a_r_rd_en}), 64'(0));
        chk("rst_data", {a_d1, a_d2}, 64'(0));
        chk("rst_tags", 64'({a_first, a_last, a_vec}), 64'(0));
        @(posedge clk); #1;
        a_ready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4; i++) qa[i] = 32'(i + 1);
        for (int i = 0; i < 8; i++) ra[i] = 32'(i + 5);
        qb[0] = 32'd7;  qb[1] = 32'd9;
        rb[0] = 32'd20; rb[1] = 32'd30;
        rst = 1'b1;
        a_start = 1'b0; a_ready = 1'b1;
        b_start = 1'b0; b_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ctl", 64'({a_busy, a_done, a_q_rd_en, a_r_rd_en, a_valid}), 64'(0));
        chk("reset_addr", 64'({a_q_addr, a_r_addr}), 64'(0));
        chk("reset_data", {a_d1, a_d2}, 64'(0));
        chk("reset_tags", 64'({a_first, a_last, a_vec}), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        run_a(0, 3);
        run_a(1, 3);
        run_a(2, 3);
        reset_mid_run();
        run_a(0, 3);
        run_a(0, 0);
        run_a(0, 3);
        run_b();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
